// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 memory responder.
// One-hot FSM encoding, IO window default and bus error codes.
// Also provides the RAM index width helper.
package femto_bus_pkg;

   // One-hot responder states
   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      RD_WAIT = 4'b0010,
      IO_ACC  = 4'b0100,
      IO_DONE = 4'b1000
   } stateT;

   // Address bit that selects the peripheral window
   localparam int IO_BIT_DEFAULT = 22;

   // Reasons for raising the sticky bus error
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_TIMEOUT  = 2'd1,
      ERR_PROTOCOL = 2'd2
   } errCodeT;

   // Number of word-index bits needed to address a RAM of 'words' entries
   function automatic int ramIdxWidth(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/femto_mem_responder_if.sv
// CPU-side FemtoRV32 memory bus.
// master = core, slave = memory responder.
// Busy flags provide the only backpressure towards the core.
interface femto_mem_responder_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic        mem_rbusy;
   logic        mem_wbusy;

   modport master (
      output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      input  mem_rdata, mem_rbusy, mem_wbusy
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      output mem_rdata, mem_rbusy, mem_wbusy
   );
endinterface

// File: rtl/femto_bram_bytewe.sv
// Single-port word RAM with per-byte write enables, block-RAM inferable.
// Read latency: one cycle; rdata holds its value while en is low.
// No backpressure; contents are not reset.
module femto_bram_bytewe #(
   parameter int WORDS = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // Byte-lane writes and registered read, read-first on the same port
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      if (en) rdata <= mem[addr];
   end

endmodule

// File: rtl/femto_mem_responder.sv
// Memory target for FemtoRV32: word RAM plus a req/ack window to peripherals.
// RAM reads take 1+READ_WAIT cycles, RAM writes complete in one edge, IO waits for ack or timeout.
// mem_rbusy/mem_wbusy stall the core; requests arriving outside IDLE are dropped and flagged.
module femto_mem_responder
   import femto_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 24,
   parameter int MEM_WORDS  = 4096,
   parameter int READ_WAIT  = 0,
   parameter int IO_BIT     = IO_BIT_DEFAULT,
   parameter int IO_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   femto_mem_responder_if.slave bus,
   output logic [7:0]          io_addr,
   output logic [31:0]         io_wdata,
   output logic                io_we,
   output logic [3:0]          io_wmask,
   output logic                io_req,
   input  logic                io_ack,
   input  logic [31:0]         io_rdata,
   output logic                bus_err
);

   localparam int          AW           = ramIdxWidth(MEM_WORDS);
   localparam logic [32:0] ADDR_SPAN    = 33'h1 << ADDR_WIDTH;
   localparam logic [31:0] ADDR_MASK    = 32'(ADDR_SPAN - 33'h1);
   localparam logic [15:0] TIMEOUT_LOAD = 16'(IO_TIMEOUT);
   localparam logic [15:0] RDWAIT_LOAD  = 16'(READ_WAIT);

   stateT       state;
   errCodeT     errCode;
   logic [15:0] waitCnt;
   logic        rbusy;
   logic        wbusy;
   logic        rdSrcRam;   // 1: read data comes straight from the RAM output register
   logic [31:0] rdataReg;
   logic [31:0] ramQ;
   logic [31:0] addrEff;
   logic        unusedAddr;
   logic        isIo;
   logic        isRd;
   logic        isWr;
   logic        inIdle;
   logic        ioExpire;
   logic        ramEn;
   logic [3:0]  ramWe;

   assign addrEff    = bus.mem_addr & ADDR_MASK;
   assign unusedAddr = ^addrEff;
   assign isIo       = addrEff[IO_BIT];
   assign isRd       = bus.mem_rstrb;
   assign isWr       = |bus.mem_wmask;
   assign inIdle     = (state == IDLE);
   assign ioExpire   = (state == IO_ACC) && !io_ack && (waitCnt <= 16'd1);

   // A write wins over a simultaneous read; reset suppresses both
   assign ramWe = (reset && inIdle && !isIo) ? bus.mem_wmask : 4'b0000;
   assign ramEn = reset && inIdle && !isIo && isRd && !isWr;

   femto_bram_bytewe #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ramEn),
      .we    (ramWe),
      .addr  (addrEff[AW+1:2]),
      .wdata (bus.mem_wdata),
      .rdata (ramQ)
   );

   assign bus.mem_rdata = rdSrcRam ? ramQ : rdataReg;
   assign bus.mem_rbusy = rbusy;
   assign bus.mem_wbusy = wbusy;

   // Classify this cycle's error condition, timeout taking precedence
   always_comb begin
      errCode = ERR_NONE;
      if (inIdle) begin
         if (isRd && isWr) errCode = ERR_PROTOCOL;
      end else if (isRd || isWr) begin
         errCode = ERR_PROTOCOL;
      end
      if (ioExpire) errCode = ERR_TIMEOUT;
   end

   // Responder FSM: RAM wait states, IO handshake with timeout, sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         waitCnt  <= '0;
         rbusy    <= 1'b0;
         wbusy    <= 1'b0;
         rdSrcRam <= 1'b0;
         rdataReg <= '0;
         io_addr  <= '0;
         io_wdata <= '0;
         io_we    <= 1'b0;
         io_wmask <= '0;
         io_req   <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         if (errCode != ERR_NONE) bus_err <= 1'b1;
         case (state)
            IDLE: begin
               if (isIo && (isRd || isWr)) begin
                  io_addr  <= addrEff[9:2];
                  io_wdata <= bus.mem_wdata;
                  io_wmask <= bus.mem_wmask;
                  io_we    <= isWr;
                  io_req   <= 1'b1;
                  rbusy    <= !isWr;
                  wbusy    <= isWr;
                  waitCnt  <= TIMEOUT_LOAD;
                  state    <= IO_ACC;
               end else if (isRd && !isWr) begin
                  if (READ_WAIT == 0) begin
                     rdSrcRam <= 1'b1;
                  end else begin
                     rbusy   <= 1'b1;
                     waitCnt <= RDWAIT_LOAD;
                     state   <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (waitCnt <= 16'd1) begin
                  rbusy    <= 1'b0;
                  rdataReg <= ramQ;
                  rdSrcRam <= 1'b0;
                  state    <= IDLE;
               end else begin
                  waitCnt <= waitCnt - 16'd1;
               end
            end
            IO_ACC: begin
               if (io_ack) begin
                  io_req <= 1'b0;
                  if (!io_we) begin
                     rdataReg <= io_rdata;
                     rdSrcRam <= 1'b0;
                  end
                  state <= IO_DONE;
               end else if (waitCnt <= 16'd1) begin
                  io_req <= 1'b0;
                  if (!io_we) begin
                     rdataReg <= '0;
                     rdSrcRam <= 1'b0;
                  end
                  state <= IO_DONE;
               end else begin
                  waitCnt <= waitCnt - 16'd1;
               end
            end
            IO_DONE: begin
               rbusy <= 1'b0;
               wbusy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_femto_mem_responder.sv
// Bench for femto_mem_responder: two instances (READ_WAIT 0 and 3) driven in lockstep.
// A reference RAM array and a sticky error flag predict every observed value.
// Peripheral side is a scripted ack generator with a configurable delay.
module tb_femto_mem_responder;

   localparam int MW  = 256;
   localparam int TMO = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpuAddr, cpuWdata;
   logic [3:0]  cpuWmask;
   logic        cpuRstrb;
   logic        ioAck;
   logic [31:0] ioRdata;

   logic [7:0]  ioAddrA, ioAddrB;
   logic [31:0] ioWdataA, ioWdataB;
   logic        ioWeA, ioWeB, ioReqA, ioReqB, busErrA, busErrB;
   logic [3:0]  ioWmaskA, ioWmaskB;

   logic [31:0] refMem [MW];
   logic        errFlag;
   int          nCompared = 0;
   int          nMismatched = 0;

   always #5 clk = ~clk;

   femto_mem_responder_if busA ();
   femto_mem_responder_if busB ();

   assign busA.mem_addr  = cpuAddr;
   assign busA.mem_wdata = cpuWdata;
   assign busA.mem_wmask = cpuWmask;
   assign busA.mem_rstrb = cpuRstrb;
   assign busB.mem_addr  = cpuAddr;
   assign busB.mem_wdata = cpuWdata;
   assign busB.mem_wmask = cpuWmask;
   assign busB.mem_rstrb = cpuRstrb;

   femto_mem_responder #(.ADDR_WIDTH(24), .MEM_WORDS(MW), .READ_WAIT(0), .IO_BIT(22), .IO_TIMEOUT(TMO)) dutA (
      .clk(clk), .reset(reset), .bus(busA),
      .io_addr(ioAddrA), .io_wdata(ioWdataA), .io_we(ioWeA), .io_wmask(ioWmaskA),
      .io_req(ioReqA), .io_ack(ioAck), .io_rdata(ioRdata), .bus_err(busErrA));

   femto_mem_responder #(.ADDR_WIDTH(24), .MEM_WORDS(MW), .READ_WAIT(3), .IO_BIT(22), .IO_TIMEOUT(TMO)) dutB (
      .clk(clk), .reset(reset), .bus(busB),
      .io_addr(ioAddrB), .io_wdata(ioWdataB), .io_we(ioWeB), .io_wmask(ioWmaskB),
      .io_req(ioReqB), .io_ack(ioAck), .io_rdata(ioRdata), .bus_err(busErrB));

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int wordIdx(input logic [31:0] a);
      return int'((a & 32'h00FF_FFFF) >> 2) % MW;
   endfunction

   task automatic checkErr(input string tag);
      checkVal({tag, "_errA"}, 32'(busErrA), 32'(errFlag));
      checkVal({tag, "_errB"}, 32'(busErrB), 32'(errFlag));
   endtask

   task automatic checkCleared(input string tag);
      checkVal({tag, "_rdataA"}, busA.mem_rdata, 32'h0);
      checkVal({tag, "_rdataB"}, busB.mem_rdata, 32'h0);
      checkVal({tag, "_busyA"}, 32'({busA.mem_rbusy, busA.mem_wbusy}), 32'h0);
      checkVal({tag, "_busyB"}, 32'({busB.mem_rbusy, busB.mem_wbusy}), 32'h0);
      checkVal({tag, "_reqA"}, 32'({ioReqA, ioWeA}), 32'h0);
      checkVal({tag, "_reqB"}, 32'({ioReqB, ioWeB}), 32'h0);
      checkVal({tag, "_ioA"}, ioWdataA ^ 32'({ioAddrA, ioWmaskA}), 32'h0);
      checkErr(tag);
   endtask

   // RAM store: one cycle with a nonzero mask
   task automatic ramWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int idx;
      idx = wordIdx(a);
      cpuAddr = a; cpuWdata = d; cpuWmask = m;
      @(negedge clk);
      cpuWmask = 4'h0;
      for (int i = 0; i < 4; i++)
         if (m[i]) refMem[idx][i*8 +: 8] = d[i*8 +: 8];
      checkVal("wr_wbusyA", 32'(busA.mem_wbusy), 32'h0);
   endtask

   // RAM load: measures busy cycles on each instance and checks the returned word
   task automatic ramRead(input string tag, input logic [31:0] a);
      int latA, latB;
      logic [31:0] dA, dB, exp;
      exp = refMem[wordIdx(a)];
      latA = -1; latB = -1; dA = 'x; dB = 'x;
      cpuAddr = a; cpuRstrb = 1'b1;
      @(negedge clk);
      cpuRstrb = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (latA < 0 && !busA.mem_rbusy) begin latA = k; dA = busA.mem_rdata; end
         if (latB < 0 && !busB.mem_rbusy) begin latB = k; dB = busB.mem_rdata; end
         if (latA >= 0 && latB >= 0) break;
         @(negedge clk);
      end
      checkVal({tag, "_latA"}, latA, 0);
      checkVal({tag, "_latB"}, latB, 3);
      checkVal({tag, "_dataA"}, dA, exp);
      checkVal({tag, "_dataB"}, dB, exp);
   endtask

   // IO access; ackAt = n acks on the n-th cycle of io_req, 0 = never. poke issues a stray rstrb mid-access.
   task automatic ioAccess(input string tag, input logic [31:0] a, input bit wr, input logic [31:0] d,
                           input logic [3:0] m, input int ackAt, input logic [31:0] rv, input bit poke);
      int  hiA, hiB, expHi;
      bit  tmo;
      tmo   = (ackAt == 0) || (ackAt > TMO);
      expHi = tmo ? TMO : ackAt;
      cpuAddr = a; cpuWdata = d;
      if (wr) cpuWmask = m; else cpuRstrb = 1'b1;
      @(negedge clk);
      cpuWmask = 4'h0; cpuRstrb = 1'b0;
      checkVal({tag, "_ioaddr"}, 32'(ioAddrA), 32'(a[9:2]));
      checkVal({tag, "_ioaddrB"}, 32'(ioAddrB), 32'(a[9:2]));
      checkVal({tag, "_iowe"}, 32'({ioWeA, ioWmaskA}), 32'({wr, wr ? m : 4'h0}));
      checkVal({tag, "_iowdata"}, ioWdataA, d);
      checkVal({tag, "_busyA"}, 32'({busA.mem_rbusy, busA.mem_wbusy}), wr ? 32'h1 : 32'h2);
      hiA = 0; hiB = 0;
      for (int k = 0; k < 40; k++) begin
         if (!ioReqA && !ioReqB) break;
         if (ioReqA) hiA++;
         if (ioReqB) hiB++;
         cpuRstrb = poke && (hiA == 2);
         ioAck    = (hiA == ackAt);
         ioRdata  = rv;
         @(negedge clk);
      end
      ioAck = 1'b0; cpuRstrb = 1'b0;
      checkVal({tag, "_reqHiA"}, hiA, expHi);
      checkVal({tag, "_reqHiB"}, hiB, expHi);
      @(negedge clk);
      checkVal({tag, "_doneA"}, 32'({busA.mem_rbusy, busA.mem_wbusy}), 32'h0);
      checkVal({tag, "_doneB"}, 32'({busB.mem_rbusy, busB.mem_wbusy}), 32'h0);
      if (!wr) begin
         checkVal({tag, "_rdataA"}, busA.mem_rdata, tmo ? 32'h0 : rv);
         checkVal({tag, "_rdataB"}, busB.mem_rdata, tmo ? 32'h0 : rv);
      end
      if (tmo || poke) errFlag = 1'b1;
      checkErr(tag);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d, old;
      reset = 1'b0; errFlag = 1'b0;
      cpuAddr = '0; cpuWdata = '0; cpuWmask = '0; cpuRstrb = 1'b0;
      ioAck = 1'b0; ioRdata = '0;
      repeat (3) @(negedge clk);
      checkCleared("reset");
      reset = 1'b1;
      @(negedge clk);

      // Directed RAM cases
      ramWrite(32'h10, 32'hCAFE_BABE, 4'hF);
      ramRead("cafe", 32'h10);
      ramWrite(32'h10, 32'h1122_3344, 4'hF);
      ramWrite(32'h10, 32'h00AA_00AA, 4'b0100);
      ramRead("lane2", 32'h10);
      checkVal("lane2_const", refMem[4], 32'h11AA_3344);

      // Fill the whole RAM so every later read has a defined expectation
      for (int i = 0; i < MW; i++)
         ramWrite((32'(i) << 2) | ($urandom & 32'hFF80_0000), $urandom, 4'hF);

      // Index wrap and ignored upper address bits
      ramWrite(32'h0, 32'h0BAD_F00D, 4'hF);
      ramRead("wrap", 32'h400);
      ramRead("hibits", 32'hFF00_0000);

      // Randomised RAM traffic
      for (int n = 0; n < 80; n++) begin
         a = $urandom & ~32'h0040_0000;
         if ($urandom_range(0, 1) == 1) ramWrite(a, $urandom, 4'($urandom_range(1, 15)));
         else ramRead("rnd", a);
      end
      checkErr("rnd");

      // IO window
      ioAccess("ioRd", 32'h0040_0008, 1'b0, 32'h0, 4'h0, 5, 32'h55, 1'b0);
      ioAccess("ioWrEdge", 32'h0040_0004, 1'b1, 32'hA5A5_0F0F, 4'b0011, TMO, 32'h0, 1'b0);
      ramRead("afterIo", 32'h24);
      ioAccess("ioTmo", 32'h0040_0004, 1'b1, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0);
      ramRead("afterTmo", 32'h30);
      checkErr("sticky");

      // Reset in the middle of an IO access
      cpuAddr = 32'h0040_0010; cpuRstrb = 1'b1;
      @(negedge clk);
      cpuRstrb = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      errFlag = 1'b0;
      checkCleared("rstIo");
      // A store presented while reset is held must not land
      old = refMem[wordIdx(32'h40)];
      cpuAddr = 32'h40; cpuWdata = ~old; cpuWmask = 4'hF;
      @(negedge clk);
      cpuWmask = 4'h0; reset = 1'b1;
      @(negedge clk);
      ramRead("rstNoWr", 32'h40);

      // Read and write strobed together: write wins, read ignored, error flagged
      d = $urandom;
      cpuAddr = 32'h44; cpuWdata = d; cpuWmask = 4'hF; cpuRstrb = 1'b1;
      @(negedge clk);
      cpuWmask = 4'h0; cpuRstrb = 1'b0;
      refMem[wordIdx(32'h44)] = d;
      errFlag = 1'b1;
      checkVal("both_rbusyB", 32'(busB.mem_rbusy), 32'h0);
      checkErr("both");
      @(negedge clk);
      ramRead("bothData", 32'h44);

      // Stray strobe while an IO access is outstanding
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; errFlag = 1'b0;
      @(negedge clk);
      checkErr("rst2");
      ioAccess("ioPoke", 32'h0040_00FC, 1'b0, 32'h0, 4'h0, 4, 32'hDEAD_BEEF, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
